// File: rtl/pio_int_ctrl.sv
// Per-port interrupt-source stage of the Z8420 PIO model.
// Decodes control-register writes, evaluates the mode-3 bit-match condition or
// the mode 0-2 handshake strobe, and feeds INTI/INTEN to the daisy-chain block.
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   CTL_WR, DI      control-register write strobe and CPU data
//   PIN             port pin levels (synchronous to CLK)
//   STB_EVT         handshake-strobe event (modes 0-2)
//   VECTEN          vector enable from the daisy chain
//   INTI, INTEN     interrupt request pulse / interrupt enable level
//   MODE, IO_DIR    current mode and mode-3 direction register (1 = input)
//   VECT_OUT        vector byte {VEC[7:1],0}; VECT_OE drives it onto the bus
module pio_int_ctrl #(
  parameter logic [1:0] RESET_MODE = 2'b01
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CTL_WR,
  input  logic [7:0] DI,
  input  logic [7:0] PIN,
  input  logic       STB_EVT,
  input  logic       VECTEN,
  output logic       INTI,
  output logic       INTEN,
  output logic [1:0] MODE,
  output logic [7:0] IO_DIR,
  output logic [7:0] VECT_OUT,
  output logic       VECT_OE
);

  localparam int unsigned DW = 8;
  localparam logic [1:0]  MODE_BIT = 2'b11;

  typedef enum logic [1:0] {
    ST_CMD   = 2'b00,
    ST_IODIR = 2'b01,
    ST_MASK  = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    mode, mode_nxt;
  logic [DW-1:0] io_dir, io_dir_nxt;
  logic [DW-1:0] mask, mask_nxt;
  logic [6:0]    vec, vec_nxt;
  logic          ie, ie_nxt;
  logic          and_or, and_or_nxt;
  logic          hi_lo, hi_lo_nxt;
  logic          ie_pend, ie_pend_nxt;
  logic          match_q;
  logic          inti;
  logic          match_c;
  logic [DW-1:0] active, at_lvl;

  // Control-register write decoder: next state and next register values
  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode;
    io_dir_nxt  = io_dir;
    mask_nxt    = mask;
    vec_nxt     = vec;
    ie_nxt      = ie;
    and_or_nxt  = and_or;
    hi_lo_nxt   = hi_lo;
    ie_pend_nxt = ie_pend;
    if (CTL_WR) begin
      case (state)
        ST_CMD: begin
          if (!DI[0]) begin
            vec_nxt = DI[7:1];
          end else if (DI[3:0] == 4'b1111) begin
            mode_nxt = DI[7:6];
            if (DI[7:6] == MODE_BIT) state_nxt = ST_IODIR;
          end else if (DI[3:0] == 4'b0111) begin
            ie_nxt     = DI[7];
            and_or_nxt = DI[6];
            hi_lo_nxt  = DI[5];
            // Mask word follows: hold IE off until the mask is in place
            if (DI[4]) begin
              ie_nxt      = 1'b0;
              ie_pend_nxt = DI[7];
              state_nxt   = ST_MASK;
            end
          end else if (DI[3:0] == 4'b0011) begin
            ie_nxt = DI[7];
          end
        end
        ST_IODIR: begin
          io_dir_nxt = DI;
          state_nxt  = ST_CMD;
        end
        ST_MASK: begin
          mask_nxt  = DI;
          ie_nxt    = ie_pend;
          state_nxt = ST_CMD;
        end
        default: state_nxt = ST_CMD;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_CMD;
    else       state <= state_nxt;
  end

  // Control registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode    <= RESET_MODE;
      io_dir  <= '1;
      mask    <= '1;
      vec     <= '0;
      ie      <= 1'b0;
      and_or  <= 1'b0;
      hi_lo   <= 1'b0;
      ie_pend <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      io_dir  <= io_dir_nxt;
      mask    <= mask_nxt;
      vec     <= vec_nxt;
      ie      <= ie_nxt;
      and_or  <= and_or_nxt;
      hi_lo   <= hi_lo_nxt;
      ie_pend <= ie_pend_nxt;
    end
  end

  // Mode-3 match on current registers; no active bits never matches
  assign active  = io_dir & ~mask;
  assign at_lvl  = hi_lo ? PIN : ~PIN;
  assign match_c = and_or ? ((active != '0) && ((active & ~at_lvl) == '0))
                          : ((active & at_lvl) != '0);

  // Interrupt request: match rising edge in mode 3, strobe echo otherwise
  always_ff @(posedge CLK) begin
    if (RESET) begin
      match_q <= 1'b0;
      inti    <= 1'b0;
    end else if (mode == MODE_BIT) begin
      match_q <= match_c;
      inti    <= match_c & ~match_q;
    end else begin
      match_q <= 1'b0;
      inti    <= STB_EVT;
    end
  end

  assign INTI     = inti;
  assign INTEN    = ie;
  assign MODE     = mode;
  assign IO_DIR   = io_dir;
  assign VECT_OUT = {vec, 1'b0};
  assign VECT_OE  = VECTEN;

endmodule

// File: tb/tb_pio_int_ctrl.sv
// Self-checking bench for pio_int_ctrl: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_pio_int_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CTL_WR = 1'b0;
  logic [7:0] DI = 8'h00;
  logic [7:0] PIN = 8'h00;
  logic       STB_EVT = 1'b0;
  logic       VECTEN = 1'b0;
  logic       INTI, INTEN, VECT_OE;
  logic [1:0] MODE;
  logic [7:0] IO_DIR, VECT_OUT;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  pio_int_ctrl #(.RESET_MODE(2'b01)) dut (
    .CLK(CLK), .RESET(RESET), .CTL_WR(CTL_WR), .DI(DI), .PIN(PIN),
    .STB_EVT(STB_EVT), .VECTEN(VECTEN), .INTI(INTI), .INTEN(INTEN),
    .MODE(MODE), .IO_DIR(IO_DIR), .VECT_OUT(VECT_OUT), .VECT_OE(VECT_OE)
  );

  always #5 CLK = ~CLK;

  // Reference model state: what the port looks like from the outside
  logic [1:0] m_mode;
  logic [7:0] m_iodir, m_mask, m_vect;
  logic       m_ie, m_andor, m_hilo, m_pend, m_prev_match, m_inti;
  int         m_next_write;  // 0 = command, 1 = direction byte, 2 = mask byte

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Count of monitored input bits sitting at the active level decides the match
  function automatic logic model_match(input logic [7:0] pin);
    int act = 0;
    int hit = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_iodir[i] && !m_mask[i]) begin
        act++;
        if (pin[i] == m_hilo) hit++;
      end
    end
    if (act == 0) return 1'b0;
    return m_andor ? (hit == act) : (hit > 0);
  endfunction

  task automatic model_reset();
    m_mode = 2'b01; m_iodir = 8'hFF; m_mask = 8'hFF; m_vect = 8'h00;
    m_ie = 1'b0; m_andor = 1'b0; m_hilo = 1'b0; m_pend = 1'b0;
    m_prev_match = 1'b0; m_inti = 1'b0; m_next_write = 0;
  endtask

  task automatic model_clock(input logic rst, input logic wr, input logic [7:0] d,
                             input logic [7:0] p, input logic stb);
    logic mt;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == 2'd3) begin
      mt = model_match(p);
      m_inti = mt && !m_prev_match;
      m_prev_match = mt;
    end else begin
      m_inti = stb;
      m_prev_match = 1'b0;
    end
    if (wr) begin
      if (m_next_write == 1) begin
        m_iodir = d; m_next_write = 0;
      end else if (m_next_write == 2) begin
        m_mask = d; m_ie = m_pend; m_next_write = 0;
      end else if (d[0] == 1'b0) begin
        m_vect = {d[7:1], 1'b0};
      end else if (d[3:0] == 4'hF) begin
        m_mode = d[7:6];
        if (d[7:6] == 2'd3) m_next_write = 1;
      end else if (d[3:0] == 4'h7) begin
        m_andor = d[6]; m_hilo = d[5];
        if (d[4]) begin
          m_ie = 1'b0; m_pend = d[7]; m_next_write = 2;
        end else begin
          m_ie = d[7];
        end
      end else if (d[3:0] == 4'h3) begin
        m_ie = d[7];
      end
    end
  endtask

  // One clock cycle: drive, check the combinational enable, clock, compare
  task automatic cyc(input logic rst, input logic wr, input logic [7:0] d,
                     input logic [7:0] p, input logic stb, input logic ven);
    RESET = rst; CTL_WR = wr; DI = d; PIN = p; STB_EVT = stb; VECTEN = ven;
    #1;
    check("vect_oe", 32'(VECT_OE), 32'(ven));
    @(posedge CLK);
    model_clock(rst, wr, d, p, stb);
    #1;
    check("inti", 32'(INTI), 32'(m_inti));
    check("inten", 32'(INTEN), 32'(m_ie));
    check("mode", 32'(MODE), 32'(m_mode));
    check("io_dir", 32'(IO_DIR), 32'(m_iodir));
    check("vect_out", 32'(VECT_OUT), 32'(m_vect));
    if (INTI) pulse_cnt++;
  endtask

  task automatic wr(input logic [7:0] d, input logic [7:0] p);
    cyc(1'b0, 1'b1, d, p, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, p, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  d, p;
    logic        w, s, v, rs;
    model_reset();
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("rst_mode", 32'(MODE), 32'h1);
    check("rst_iodir", 32'(IO_DIR), 32'hFF);
    check("rst_inten", 32'(INTEN), 32'h0);

    // Vector write and vector enable
    wr(8'h20, 8'h00);
    check("t1_vect", 32'(VECT_OUT), 32'h20);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Mode 3, OR, active-high, one monitored bit
    wr(8'hCF, 8'h00); wr(8'h0F, 8'h00); wr(8'hB7, 8'h00);
    check("t2_inten_held", 32'(INTEN), 32'h0);
    wr(8'hFE, 8'h00);
    check("t2_inten_on", 32'(INTEN), 32'h1);
    idle(8'h00, 2);
    pulse_cnt = 0;
    cyc(1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
    check("t2_latency", 32'(INTI), 32'h1);
    idle(8'h01, 4);
    check("t2_pulses", 32'(pulse_cnt), 32'h1);

    // AND mode, active-low, low nibble monitored
    wr(8'hCF, 8'h0E); wr(8'hFF, 8'h0E); wr(8'hD7, 8'h0E); wr(8'hF0, 8'h0E);
    pulse_cnt = 0;
    idle(8'h0E, 3);
    check("t3_nomatch", 32'(pulse_cnt), 32'h0);
    idle(8'h00, 3);
    check("t3_match", 32'(pulse_cnt), 32'h1);
    idle(8'h01, 2); idle(8'h00, 2);
    check("t3_rematch", 32'(pulse_cnt), 32'h2);

    // Nothing monitored never matches
    wr(8'h17, 8'h00); wr(8'hFF, 8'h00);
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) idle(8'(i * 8'h55), 1);
    wr(8'h57, 8'h00); wr(8'hFF, 8'h00);
    for (int i = 0; i < 6; i++) idle(8'(i * 8'h33), 1);
    wr(8'hCF, 8'h00); wr(8'h00, 8'h00); wr(8'h17, 8'h00); wr(8'h00, 8'h00);
    for (int i = 0; i < 6; i++) idle(8'(i * 8'h5A), 1);
    check("t4_silent", 32'(pulse_cnt), 32'h0);

    // Mode 1: strobe echoed, pins ignored, enable-only word
    wr(8'h4F, 8'h00);
    wr(8'hE7, 8'h00);
    pulse_cnt = 0;
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("t5_stb", 32'(INTI), 32'h1);
    idle(8'hFF, 2); idle(8'h00, 2);
    check("t5_pins", 32'(pulse_cnt), 32'h1);
    wr(8'h03, 8'h00);
    check("t5_ie_off", 32'(INTEN), 32'h0);

    // Reset in the mask phase; the next byte must be a command
    wr(8'h97, 8'h00);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wr(8'h55, 8'h00);
    wr(8'hCF, 8'h00); wr(8'hFF, 8'h00);
    pulse_cnt = 0;
    idle(8'h00, 2); idle(8'hFF, 2); idle(8'h00, 2);
    check("t6_mask_kept", 32'(pulse_cnt), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      r = $urandom;
      w = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0, 1:    d = r[7:0];
        2:       d = 8'hCF;
        3:       d = {r[7:4], 4'b0111};
        4:       d = {r[7:4], 4'b0011};
        5:       d = {r[7:6], 6'b001111};
        default: d = {r[7:1], 1'b0};
      endcase
      if ($urandom_range(0, 2) == 0) p = r[15:8];
      else if ($urandom_range(0, 1) == 0) p = PIN ^ 8'(1 << r[18:16]);
      else p = PIN;
      s  = ($urandom_range(0, 4) == 0);
      v  = r[20];
      rs = ($urandom_range(0, 299) == 0);
      cyc(rs, w, d, p, s, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pio_int_ctrl.md
Name: pio_int_ctrl

Overview:
- Per-port interrupt-source stage of the Z8420 PIO model; sits directly upstream of the daisy-chain interrupt block.
- Decodes PIO control-register writes (vector, mode, interrupt control, mask, I/O direction, enable flip-flop).
- Evaluates the mode-3 bit-match condition or the mode 0–2 handshake strobe.
- Produces the INTI pulse and INTEN level consumed by the daisy-chain block. Returns the vector byte when that block asserts VECTEN.

Parameters:
RESET_MODE, 2'b01, mode loaded on reset (01 = input)

Ports:
CLK  in  1  system clock; all state updates on rising edge
RESET  in  1  reset, synchronous, active-high
CTL_WR  in  1  one-cycle strobe: DI is a control-register write for this port
DI  in  8  CPU data bus
PIN  in  8  port pin levels, already synchronous to CLK
STB_EVT  in  1  one-cycle handshake-strobe event from the port handshake logic (modes 0–2)
VECTEN  in  1  vector enable from the daisy-chain block
INTI  out  1  interrupt request pulse to the daisy-chain block
INTEN  out  1  interrupt enable level to the daisy-chain block
MODE  out  2  current operating mode
IO_DIR  out  8  mode-3 direction register; 1 = input
VECT_OUT  out  8  vector byte {VEC[7:1],0}
VECT_OE  out  1  drive VECT_OUT onto CPU bus

Behaviour:
- Reset values: MODE=RESET_MODE, IO_DIR=FF, MASK=FF (1 = bit ignored), VEC=00, IE=0, AND_OR=0 (OR), HI_LO=0 (active low), state=CMD, match_q=0. Outputs: INTI=0, INTEN=0, VECT_OUT=00, VECT_OE=0.
- Reset mid-sequence (for example in MASK state) aborts the sequence and reloads all reset values.
- The write decoder is a 3-state FSM. Every CTL_WR is consumed by exactly one state; writes without CTL_WR are ignored.
- State CMD decodes the write as follows:
  - DI[0]=0: VEC<=DI[7:1]. Stay in CMD.
  - DI[3:0]=1111: MODE<=DI[7:6]. If DI[7:6]=11, go to IODIR; otherwise stay in CMD.
  - DI[3:0]=0111: IE<=DI[7], AND_OR<=DI[6], HI_LO<=DI[5].
    - If DI[4]=1: go to MASK and force IE<=0 regardless of DI[7]. Record DI[7] as ie_pend.
  - DI[3:0]=0011: IE<=DI[7]. AND_OR, HI_LO and MASK are unchanged.
  - Any other DI: ignored.
- State IODIR: the next CTL_WR sets IO_DIR<=DI, then go to CMD. DI is not decoded as a command.
- State MASK: the next CTL_WR sets MASK<=DI and IE<=ie_pend, then go to CMD.
- INTEN = IE, registered.
- Mode-3 match, combinational on current registers:
  - Active bit i: IO_DIR[i]=1 and MASK[i]=0.
  - Bit at active level: PIN[i]==HI_LO.
  - OR mode: match = any active bit is at active level.
  - AND mode: match = every active bit is at active level.
  - No active bits: match=0 in both modes.
- match_q <= match when MODE=11, else 0.
- INTI in mode 3: registered one-cycle pulse on a rising edge of match (match=1 and match_q=0).
  - Latency: one CLK after the PIN, MASK, IO_DIR or control change that creates the match.
  - A match held high gives no further pulses; it must drop and re-rise.
- INTI in modes 0–2: INTI <= STB_EVT, one-cycle latency.
- INTI is generated independent of IE; gating is done downstream.
  - A match that rises while IE=0 is lost. Enabling later while match stays 1 raises no request.
- Mode change away from 11: match_q clears on the next cycle.
  - On return to mode 3, an existing match produces a fresh pulse.
- Simultaneous events:
  - A CTL_WR that changes MASK, IO_DIR, HI_LO or AND_OR takes effect on the same edge.
  - Match is evaluated on the next cycle against the new values.
  - STB_EVT arriving in mode 3 is ignored.
- VECT_OUT = {VEC,0} at all times. VECT_OE = VECTEN, combinational; no VEC write is blocked while VECT_OE=1.

Test Plan:
1. Reset, then CTL_WR DI=0x20 -> VECT_OUT=0x20. VECTEN=1 -> VECT_OE=1 in the same cycle. INTEN=0, MODE=01, IO_DIR=FF.
2. Set up mode 3: CTL_WR 0xCF, 0x0F (IO_DIR=0F), 0xB7 (IE, OR, active-high, mask follows) -> INTEN=0. Then CTL_WR 0xFE -> MASK=FE, INTEN=1. PIN 0x00->0x01 -> single INTI pulse exactly 1 cycle later. PIN held at 0x01 -> no further pulses.
3. AND mode with MASK=F0, IO_DIR=FF, active-low (ctl 0xD7 + mask 0xF0):
   - PIN=0x0E -> no INTI.
   - PIN=0x00 -> INTI pulse.
   - PIN=0x01 then 0x00 -> a second pulse.
4. MASK=FF in mode 3, both AND and OR, PIN toggled -> INTI stays 0. IO_DIR=00 with MASK=00 -> INTI stays 0.
5. Mode 1 (CTL_WR 0x4F): STB_EVT pulse -> INTI pulse 1 cycle later. PIN changes -> no INTI. Enable-FF word 0x03 -> INTEN=0 while AND_OR/HI_LO are retained.
6. Assert RESET while in MASK state (after 0x97) -> state CMD, INTEN=0, MASK=FF. A following CTL_WR 0x55 is decoded as a command (ignored), not loaded as a mask.
